// File: rtl/bus_arbiter3.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter3
// Purpose  : Three-source round-robin bus arbiter with burst-limited grants
//            and a guaranteed bus-idle turnaround between owners.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter3 #(
  parameter int BURST_MAX   = 4,  // max grant cycles while others wait (1..15)
  parameter int TURN_CYCLES = 1   // idle cycles after every grant (1..7)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_req,
  output logic [2:0] o_gnt,
  output logic [1:0] o_sel,
  output logic       o_bus_oe
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  localparam logic [3:0] C_BURST_MAX = 4'(BURST_MAX);
  localparam logic [2:0] C_TURN      = 3'(TURN_CYCLES);

  state_t     r_state, w_state;
  logic [2:0] r_gnt,   w_gnt;
  logic [1:0] r_sel,   w_sel;
  logic [1:0] r_last,  w_last;
  logic [3:0] r_burst, w_burst;
  logic [2:0] r_turn,  w_turn;

  logic [1:0] w_win;
  logic       w_win_valid;
  logic       w_owner_req;
  logic       w_others;
  logic       w_arb;

  // Round-robin winner: start searching just after the last owner, the last
  // owner itself comes last. The final else is only reached when it alone
  // (or nobody) requests, and w_win_valid qualifies the no-request case.
  always_comb begin
    w_win_valid = |i_req;
    w_win       = 2'd0;
    case (r_last)
      2'd0: begin
        if (i_req[1])      w_win = 2'd1;
        else if (i_req[2]) w_win = 2'd2;
        else               w_win = 2'd0;
      end
      2'd1: begin
        if (i_req[2])      w_win = 2'd2;
        else if (i_req[0]) w_win = 2'd0;
        else               w_win = 2'd1;
      end
      default: begin
        if (i_req[0])      w_win = 2'd0;
        else if (i_req[1]) w_win = 2'd1;
        else               w_win = 2'd2;
      end
    endcase
  end

  // Current owner still requesting, and whether anyone else is waiting.
  always_comb begin
    w_owner_req = |(i_req & r_gnt);
    w_others    = |(i_req & ~r_gnt);
  end

  // Next-state and next-output logic; registered outputs are computed here.
  always_comb begin
    w_state = r_state;
    w_gnt   = r_gnt;
    w_sel   = r_sel;
    w_last  = r_last;
    w_burst = r_burst;
    w_turn  = r_turn;
    w_arb   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_arb = 1'b1;
      end
      S_GRANT: begin
        // Owner drop and burst expiry collapse into the same single exit.
        if (!w_owner_req || ((r_burst == C_BURST_MAX) && w_others)) begin
          w_state = S_TURN;
          w_gnt   = 3'b000;
          w_turn  = C_TURN;
        end else if (r_burst != C_BURST_MAX) begin
          w_burst = r_burst + 4'd1;
        end
      end
      S_TURN: begin
        // Requests are only looked at in the last turnaround cycle.
        if (r_turn <= 3'd1) w_arb = 1'b1;
        else                w_turn = r_turn - 3'd1;
      end
      default: begin
        w_state = S_IDLE;
        w_gnt   = 3'b000;
      end
    endcase

    if (w_arb) begin
      w_turn = 3'd0;
      if (w_win_valid) begin
        w_state = S_GRANT;
        w_gnt   = 3'b001 << w_win;
        w_sel   = w_win;
        w_last  = w_win;
        w_burst = 4'd1;
      end else begin
        w_state = S_IDLE;
        w_gnt   = 3'b000;
      end
    end
  end

  // State and output registers; reset clears the grant without a clock edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_gnt   <= 3'b000;
      r_sel   <= 2'd0;
      r_last  <= 2'd2;
      r_burst <= 4'd0;
      r_turn  <= 3'd0;
    end else begin
      r_state <= w_state;
      r_gnt   <= w_gnt;
      r_sel   <= w_sel;
      r_last  <= w_last;
      r_burst <= w_burst;
      r_turn  <= w_turn;
    end
  end

  assign o_gnt    = r_gnt;
  assign o_sel    = r_sel;
  assign o_bus_oe = |r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter3.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter3
// Purpose  : Self-checking bench for bus_arbiter3: directed vector table,
//            asynchronous reset sequence and randomized model comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter3;

  localparam int BM = 4;
  localparam int TC = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       bus_oe;

  int checks = 0;
  int errors = 0;

  bus_arbiter3 #(.BURST_MAX(BM), .TURN_CYCLES(TC)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .o_gnt   (gnt),
    .o_sel   (sel),
    .o_bus_oe(bus_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] sel;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: owner index (-1 = none), turnaround left, etc.
  int m_owner, m_last, m_burst, m_turn;
  logic [1:0] m_sel;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic [2:0] q);
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [2:0] q, input logic [2:0] g, input logic [1:0] s);
    vec_t v;
    v.rst = r; v.req = q; v.gnt = g; v.sel = s;
    vecs.push_back(v);
  endtask

  function automatic int pick(input logic [2:0] q, input int last);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (last + k) % 3;
      if (q[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 2; m_burst = 0; m_turn = 0; m_sel = 2'd0;
  endtask

  task automatic model_arbitrate(input logic [2:0] q);
    int w;
    w = pick(q, m_last);
    if (w >= 0) begin
      m_owner = w; m_last = w; m_sel = 2'(w); m_burst = 1;
    end
  endtask

  // One clock edge of the reference behaviour, given the request seen there.
  task automatic model_step(input logic [2:0] q);
    if (m_owner >= 0) begin
      logic [2:0] others;
      others = q & ~(3'b001 << m_owner);
      if (!q[m_owner] || (m_burst == BM && others != 3'b000)) begin
        m_owner = -1;
        m_turn  = TC;
      end else if (m_burst < BM) begin
        m_burst++;
      end
    end else if (m_turn > 1) begin
      m_turn--;
    end else begin
      m_turn = 0;
      model_arbitrate(q);
    end
  endtask

  function automatic logic [2:0] model_gnt();
    return (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
  endfunction

  initial begin
    // --- directed vector table --------------------------------------------
    add(1, 3'b000, 3'b000, 2'd0);
    // all three requesting from reset: bursts of 4 with 1 idle cycle between
    for (int i = 0; i < 4; i++) add(0, 3'b111, 3'b001, 2'd0);
    add(0, 3'b111, 3'b000, 2'd0);
    for (int i = 0; i < 4; i++) add(0, 3'b111, 3'b010, 2'd1);
    add(0, 3'b111, 3'b000, 2'd1);
    for (int i = 0; i < 4; i++) add(0, 3'b111, 3'b100, 2'd2);
    add(0, 3'b111, 3'b000, 2'd2);
    add(0, 3'b111, 3'b001, 2'd0);
    // B alone for 10 cycles, then release: one turn cycle, then idle
    add(1, 3'b000, 3'b000, 2'd0);
    for (int i = 0; i < 10; i++) add(0, 3'b010, 3'b010, 2'd1);
    add(0, 3'b000, 3'b000, 2'd1);
    add(0, 3'b000, 3'b000, 2'd1);
    // serve A, then A+C in idle: C wins because A was just served
    add(0, 3'b001, 3'b001, 2'd0);
    add(0, 3'b000, 3'b000, 2'd0);
    add(0, 3'b000, 3'b000, 2'd0);
    add(0, 3'b101, 3'b100, 2'd2);
    // C drops, A takes over, A drops after 2 cycles with C waiting
    add(0, 3'b001, 3'b000, 2'd2);
    add(0, 3'b001, 3'b001, 2'd0);
    add(0, 3'b101, 3'b001, 2'd0);
    add(0, 3'b100, 3'b000, 2'd0);
    add(0, 3'b100, 3'b100, 2'd2);
    // C alone beyond the burst limit: no preemption, no gaps
    for (int i = 0; i < 6; i++) add(0, 3'b100, 3'b100, 2'd2);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      tick(vecs[i].rst, vecs[i].req);
      chk($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
      chk($sformatf("vec%0d_sel", i), {1'b0, sel}, {1'b0, vecs[i].sel});
      chk($sformatf("vec%0d_oe", i), {2'b00, bus_oe}, {2'b00, |vecs[i].gnt});
    end

    // --- asynchronous reset in the middle of a B grant ----------------------
    tick(1, 3'b000);
    tick(0, 3'b010);
    tick(0, 3'b010);
    chk("async_pre_gnt", gnt, 3'b010);
    #2 rst = 1'b1;
    #1;
    chk("async_gnt", gnt, 3'b000);
    chk("async_sel", {1'b0, sel}, 3'b000);
    chk("async_oe", {2'b00, bus_oe}, 3'b000);
    tick(0, 3'b111);
    chk("after_rst_gnt", gnt, 3'b001);
    chk("after_rst_sel", {1'b0, sel}, 3'b000);

    // --- randomized comparison against the reference model ---------------
    tick(1, 3'b000);
    model_reset();
    begin
      logic [2:0] q;
      q = 3'b000;
      for (int c = 0; c < 600; c++) begin
        if (c == 300) begin
          tick(1, q);
          model_reset();
        end else begin
          if ($urandom_range(0, 3) == 0) q = 3'($urandom_range(0, 7));
          tick(0, q);
          model_step(q);
        end
        chk("rand_gnt", gnt, model_gnt());
        chk("rand_sel", {1'b0, sel}, {1'b0, m_sel});
        chk("rand_oe", {2'b00, bus_oe}, {2'b00, (m_owner >= 0)});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
